// File: rtl/udp_tx_fifo_reader.sv
// Read-side consumer of the payload FIFO: slices the byte stream into UDP payload
// packets (full MAX_LEN or timeout flush) and feeds udp_tx through its start/req/done handshake.
module udp_tx_fifo_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int USEDW_WIDTH   = 12,
  parameter int MAX_LEN       = 1024,
  parameter int FLUSH_TIMEOUT = 10000,
  parameter int IFG_CYCLES    = 12
) (
  input  logic                   rdclk,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  fifo_rddata,
  input  logic                   fifo_empty,
  input  logic [USEDW_WIDTH-1:0] fifo_rdusedw,
  output logic                   fifo_rden,
  output logic                   tx_start_en,
  output logic [15:0]            tx_byte_num,
  input  logic                   tx_req,
  output logic [DATA_WIDTH-1:0]  tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [15:0]            pkt_cnt,
  output logic                   err_underrun,
  output logic                   err_short
);

  localparam int TMO_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam int GAP_W = $clog2(IFG_CYCLES + 1);
  localparam logic [USEDW_WIDTH-1:0] MAX_LEN_U = USEDW_WIDTH'(MAX_LEN);
  localparam logic [TMO_W-1:0]       TMO_MAX   = TMO_W'(FLUSH_TIMEOUT);
  localparam logic [GAP_W-1:0]       GAP_LAST  = GAP_W'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, SEND, GAP} state_t;

  state_t                  state_reg, state_next;
  logic [TMO_W-1:0]        tmo_cnt_reg, tmo_cnt_next;
  logic [GAP_W-1:0]        gap_cnt_reg, gap_cnt_next;
  logic [USEDW_WIDTH-1:0]  len_reg, len_next;
  logic [USEDW_WIDTH-1:0]  remaining_reg, remaining_next;
  logic [DATA_WIDTH-1:0]   tx_data_reg, tx_data_next;
  logic [15:0]             tx_byte_num_reg, tx_byte_num_next;
  logic [15:0]             pkt_cnt_reg, pkt_cnt_next;
  logic                    tx_start_en_reg, tx_start_en_next;
  logic                    err_underrun_reg, err_underrun_next;
  logic                    err_short_reg, err_short_next;
  logic                    pop;

  always_ff @(posedge rdclk) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      tmo_cnt_reg      <= '0;
      gap_cnt_reg      <= '0;
      len_reg          <= '0;
      remaining_reg    <= '0;
      tx_data_reg      <= '0;
      tx_byte_num_reg  <= '0;
      pkt_cnt_reg      <= '0;
      tx_start_en_reg  <= 1'b0;
      err_underrun_reg <= 1'b0;
      err_short_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      tmo_cnt_reg      <= tmo_cnt_next;
      gap_cnt_reg      <= gap_cnt_next;
      len_reg          <= len_next;
      remaining_reg    <= remaining_next;
      tx_data_reg      <= tx_data_next;
      tx_byte_num_reg  <= tx_byte_num_next;
      pkt_cnt_reg      <= pkt_cnt_next;
      tx_start_en_reg  <= tx_start_en_next;
      err_underrun_reg <= err_underrun_next;
      err_short_reg    <= err_short_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    tmo_cnt_next      = tmo_cnt_reg;
    gap_cnt_next      = gap_cnt_reg;
    len_next          = len_reg;
    remaining_next    = remaining_reg;
    tx_data_next      = tx_data_reg;
    tx_byte_num_next  = tx_byte_num_reg;
    pkt_cnt_next      = pkt_cnt_reg;
    tx_start_en_next  = 1'b0;
    err_underrun_next = err_underrun_reg;
    err_short_next    = err_short_reg;
    pop               = 1'b0;

    case (state_reg)
      IDLE: begin
        if (fifo_rdusedw == '0)
          tmo_cnt_next = '0;
        else if (fifo_rdusedw < MAX_LEN_U && tmo_cnt_reg != TMO_MAX)
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);

        // A full packet always wins over a pending flush.
        if (fifo_rdusedw >= MAX_LEN_U) begin
          len_next     = MAX_LEN_U;
          tmo_cnt_next = '0;
          state_next   = ARM;
        end else if (tmo_cnt_reg == TMO_MAX && fifo_rdusedw != '0) begin
          len_next     = fifo_rdusedw;
          tmo_cnt_next = '0;
          state_next   = ARM;
        end
      end

      ARM: begin
        // fifo_empty can trail the fill level, so hold off the start until data is visible.
        if (!fifo_empty) begin
          tx_start_en_next = 1'b1;
          tx_byte_num_next = 16'(len_reg);
          remaining_next   = len_reg;
          pkt_cnt_next     = pkt_cnt_reg + 16'd1;
          state_next       = SEND;
        end
      end

      SEND: begin
        if (tx_req) begin
          if (remaining_reg != '0 && !fifo_empty) begin
            pop            = 1'b1;
            tx_data_next   = fifo_rddata;
            remaining_next = remaining_reg - USEDW_WIDTH'(1);
          end else begin
            tx_data_next      = '0;
            err_underrun_next = 1'b1;
          end
        end
        // A request in the same cycle as done is serviced before the owed count is judged.
        if (tx_done) begin
          if (remaining_next != '0)
            err_short_next = 1'b1;
          gap_cnt_next = '0;
          state_next   = GAP;
        end
      end

      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Never pop while reset is asserted so the FIFO is left untouched.
  assign fifo_rden    = pop & reset_n;
  assign tx_start_en  = tx_start_en_reg;
  assign tx_byte_num  = tx_byte_num_reg;
  assign tx_data      = tx_data_reg;
  assign busy         = (state_reg != IDLE);
  assign pkt_cnt      = pkt_cnt_reg;
  assign err_underrun = err_underrun_reg;
  assign err_short    = err_short_reg;

endmodule
